// File: rtl/dnn_pkg.sv
// Shared definitions for the perceptron datapath blocks: default lane count
// and widths, the derived index/pointer widths, and the result collector
// state encoding.
package dnn_pkg;

    localparam int N_DEF      = 40;
    localparam int BA_DEF     = 24;
    localparam int BB_DEF     = 8;
    localparam int LANE_IDX_W = $clog2(N_DEF);
    localparam int PTR_W      = $clog2(N_DEF + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } rc_state_t;

endpackage

// File: rtl/rc_lane_buf.sv
// N x Ba lane register file for the result collector. The write port copies
// one lane of the engine bus, selected by the write pointer. The read port
// returns the lane at the read pointer, or zero when the pointer is N.
module rc_lane_buf
    import dnn_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int Ba  = BA_DEF,
    parameter int PW  = $clog2(N + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wr_en_i,
    input  logic [PW-1:0]   wr_ptr_i,
    input  logic [N*Ba-1:0] lanes_i,
    input  logic [PW-1:0]   rd_ptr_i,
    output logic [Ba-1:0]   rd_data_o
);

    logic [Ba-1:0] mem_q [N];

    // Capture the addressed lane bit-exact; the whole file clears on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            for (int i = 0; i < N; i++) begin
                if (wr_ptr_i == PW'(i)) begin
                    mem_q[i] <= lanes_i[i*Ba +: Ba];
                end
            end
        end
    end

    // Read mux over the lanes; an out-of-range pointer reads as zero.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_ptr_i == PW'(i)) begin
                rd_data_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/result_collector.sv
// Result collector: captures the lane-skewed engine results after a stop
// pulse (lane k at LAT+k edges after stop), buffers them, and drains them
// one lane per beat on a valid/ready stream while capture continues.
// Optional feature macro: RESULT_COLLECTOR_ARGMAX_EN adds a running signed
// argmax over the drained beats.
//
// Stream handshake: a beat transfers on a rising edge where res_valid and
// res_ready are both high. While res_valid is high and res_ready is low,
// res_data and res_idx stay stable. res_valid never drops without a transfer,
// except on reset.
module result_collector
    import dnn_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int Ba  = BA_DEF,
    parameter int LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*Ba-1:0]      out_bus,
    input  logic                 stop,
`ifdef RESULT_COLLECTOR_ARGMAX_EN
    output logic [$clog2(N)-1:0] argmax_idx,
    output logic                 argmax_valid,
`endif
    output logic [Ba-1:0]        res_data,
    output logic [$clog2(N)-1:0] res_idx,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic [1:0]           dbg_state
);

    localparam int IDX_W    = $clog2(N);
    localparam int RC_PTR_W = $clog2(N + 1);
    localparam int LAT_W    = $clog2(LAT + 1);

    rc_state_t           state_q, state_d;
    logic [RC_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [RC_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic                wr_en;
    logic                accept;
    logic                last_accept;
    logic [Ba-1:0]       buf_data;

    rc_lane_buf #(
        .N  (N),
        .Ba (Ba),
        .PW (RC_PTR_W)
    ) u_lane_buf (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_en),
        .wr_ptr_i  (wr_ptr_q),
        .lanes_i   (out_bus),
        .rd_ptr_i  (rd_ptr_q),
        .rd_data_o (buf_data)
    );

    assign busy      = (state_q != IDLE);
    assign res_valid = busy && (rd_ptr_q < wr_ptr_q);
    assign res_idx   = rd_ptr_q[IDX_W-1:0];
    assign res_data  = res_valid ? buf_data : '0;
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

    // Next state, capture enable and pointer updates. Capture never waits on
    // the consumer; drain runs whenever a captured lane is still unread.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_en       = 1'b0;
        accept      = res_valid && res_ready;
        last_accept = accept && (rd_ptr_q == RC_PTR_W'(N - 1));
        done_d      = last_accept;
        overrun_d   = overrun_q | (stop && busy);

        case (state_q)
            IDLE: begin
                if (stop) begin
                    state_d   = WAIT;
                    lat_cnt_d = '0;
                end
            end
            WAIT: begin
                // Lane 0 is final LAT edges after the stop edge.
                if (lat_cnt_q == LAT_W'(LAT - 1)) begin
                    wr_en   = 1'b1;
                    state_d = (N == 1) ? DRAIN : CAPTURE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                wr_en = 1'b1;
                if (wr_ptr_q == RC_PTR_W'(N - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (last_accept) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // State, pointer, latency counter and status flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            lat_cnt_q <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            lat_cnt_q <= lat_cnt_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef RESULT_COLLECTOR_ARGMAX_EN
    logic signed [Ba-1:0] max_q, max_d;
    logic [IDX_W-1:0]     max_idx_q, max_idx_d;
    logic [IDX_W-1:0]     argmax_idx_q, argmax_idx_d;
    logic                 argmax_valid_q, argmax_valid_d;

    assign argmax_idx   = argmax_idx_q;
    assign argmax_valid = argmax_valid_q;

    // Running signed max over accepted beats; strict compare keeps the
    // lower index on ties. The final winner is published with done.
    always_comb begin
        max_d          = max_q;
        max_idx_d      = max_idx_q;
        argmax_idx_d   = argmax_idx_q;
        argmax_valid_d = last_accept;
        if (accept) begin
            if ((rd_ptr_q == '0) || ($signed(buf_data) > max_q)) begin
                max_d     = buf_data;
                max_idx_d = res_idx;
            end
        end
        if (last_accept) begin
            argmax_idx_d = max_idx_d;
        end
    end

    // Argmax tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q          <= '0;
            max_idx_q      <= '0;
            argmax_idx_q   <= '0;
            argmax_valid_q <= 1'b0;
        end else begin
            max_q          <= max_d;
            max_idx_q      <= max_idx_d;
            argmax_idx_q   <= argmax_idx_d;
            argmax_valid_q <= argmax_valid_d;
        end
    end
`endif

endmodule
